// File: rtl/pic_status_pkg.sv
// rtl/pic_status_pkg.sv - shared constants and types for the picture status register slave
// Contents: register offsets, CTRL bit indices, FSM state enum.
package pic_status_pkg;

    localparam logic [7:0] OFS_ID         = 8'h00;
    localparam logic [7:0] OFS_PIC_CNT    = 8'h04;
    localparam logic [7:0] OFS_DEPTH_SNAP = 8'h08;
    localparam logic [7:0] OFS_DEPTH_MAX  = 8'h0C;
    localparam logic [7:0] OFS_ERR        = 8'h10;
    localparam logic [7:0] OFS_CTRL       = 8'h14;

    localparam int CTRL_FREEZE  = 0;
    localparam int CTRL_CNT_CLR = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_RESP
    } state_t;

endpackage

// File: rtl/pic_status_reg_slave_if.sv
// rtl/pic_status_reg_slave_if.sv - request/response register bus between master and status slave
// Signals: req_valid/req_ready/req_write/req_addr/req_wdata (request),
//          rsp_valid/rsp_ready/rsp_data/rsp_err (response).
// Modports: master (drives requests), slave (drives responses).
interface pic_status_reg_slave_if #(
    parameter int ADDR_W = 32
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/pic_edge_sync.sv
// rtl/pic_edge_sync.sv - picture_start rising-edge detector with optional input synchronizer
// Ports: CLK, ARESETn (async active-low), picture_start (level in), pic_edge (1-cycle pulse out).
// Macro PIC_SYNC_EN: when defined, picture_start passes a 2-flop synchronizer first,
// so pic_edge is high in the third cycle after the input rise instead of the first.
module pic_edge_sync (
    input  logic CLK,
    input  logic ARESETn,
    input  logic picture_start,
    output logic pic_edge
);

    logic pic_s;
    logic pic_d;

`ifdef PIC_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge CLK or negedge ARESETn) begin
        if (!ARESETn) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], picture_start};
        end
    end

    assign pic_s = sync_q[1];
`else
    assign pic_s = picture_start;
`endif

    always_ff @(posedge CLK or negedge ARESETn) begin
        if (!ARESETn) begin
            pic_d <= 1'b0;
        end else begin
            pic_d <= pic_s;
        end
    end

    // Edge is combinational off the delayed copy so the snapshot lands on the same clock
    // edge that first sees the (possibly synchronized) level high.
    assign pic_edge = pic_s & ~pic_d;

endmodule

// File: rtl/pic_status_reg_slave.sv
// rtl/pic_status_reg_slave.sv - per-picture FIFO status registers behind a valid/ready register bus
// Ports: CLK, ARESETn (async active-low), picture_start (rise = new picture),
//        fifo_depth (current occupancy), err_in (error pulses), bus (slave modport).
// Map: 0x00 ID, 0x04 PIC_CNT, 0x08 DEPTH_SNAP, 0x0C DEPTH_MAX, 0x10 ERR_STICKY (W1C),
//      0x14 CTRL (bit0 FREEZE, bit1 CNT_CLR self-clearing).
// Macro PIC_SYNC_EN: synchronize picture_start before edge detection.
module pic_status_reg_slave
    import pic_status_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1100,
    parameter int          ADDR_W    = 32,
    parameter int          DEPTH_W   = 8,
    parameter int          ERR_W     = 8,
    parameter logic [31:0] BLOCK_ID  = 32'hC0DE_0001
) (
    input  logic                  CLK,
    input  logic                  ARESETn,
    input  logic                  picture_start,
    input  logic [DEPTH_W-1:0]    fifo_depth,
    input  logic [ERR_W-1:0]      err_in,
    pic_status_reg_slave_if.slave bus
);

    state_t              state;
    state_t              state_n;
    logic                req_ready_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rsp_data_q;
    logic                rsp_err_q;

    logic [31:0]         pic_cnt;
    logic [DEPTH_W-1:0]  depth_snap;
    logic [DEPTH_W-1:0]  depth_max;
    logic [ERR_W-1:0]    err_sticky;
    logic                freeze;

    logic                pic_edge;
    logic                pic_take;
    logic                accept;
    logic [ADDR_W-1:0]   ofs;
    logic [31:0]         dec_data;
    logic                dec_err;
    logic                hit_err;
    logic                hit_ctrl;
    logic                ctrl_we;
    logic                cnt_clr;
    logic [ERR_W-1:0]    err_w1c;
    logic                unused_wdata;

    pic_edge_sync u_edge (
        .CLK           (CLK),
        .ARESETn       (ARESETn),
        .picture_start (picture_start),
        .pic_edge      (pic_edge)
    );

    assign accept        = (state == ST_IDLE) && bus.req_valid && req_ready_q;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign unused_wdata  = ^wdata_q;

    // Address decode on the latched request. Addresses below the base wrap to huge
    // offsets and fall into the default arm.
    always_comb begin
        dec_data = '0;
        dec_err  = 1'b0;
        hit_err  = 1'b0;
        hit_ctrl = 1'b0;
        ofs      = addr_q - ADDR_W'(BASE_ADDR);
        if (addr_q[1:0] != 2'b00) begin
            dec_err = 1'b1;
        end else begin
            case (ofs)
                ADDR_W'(OFS_ID): begin
                    if (wr_q) dec_err = 1'b1;
                    else      dec_data = BLOCK_ID;
                end
                ADDR_W'(OFS_PIC_CNT): begin
                    if (wr_q) dec_err = 1'b1;
                    else      dec_data = pic_cnt;
                end
                ADDR_W'(OFS_DEPTH_SNAP): begin
                    if (wr_q) dec_err = 1'b1;
                    else      dec_data = 32'(depth_snap);
                end
                ADDR_W'(OFS_DEPTH_MAX): begin
                    if (wr_q) dec_err = 1'b1;
                    else      dec_data = 32'(depth_max);
                end
                ADDR_W'(OFS_ERR): begin
                    if (wr_q) hit_err = 1'b1;
                    else      dec_data = 32'(err_sticky);
                end
                ADDR_W'(OFS_CTRL): begin
                    if (wr_q) hit_ctrl = 1'b1;
                    else      dec_data[CTRL_FREEZE] = freeze;
                end
                default: dec_err = 1'b1;
            endcase
        end
    end

    // Register side effects only happen in the single DECODE cycle.
    assign ctrl_we  = (state == ST_DECODE) && hit_ctrl;
    assign cnt_clr  = ctrl_we && wdata_q[CTRL_CNT_CLR];
    assign err_w1c  = ((state == ST_DECODE) && hit_err) ? wdata_q[ERR_W-1:0] : '0;
    assign pic_take = pic_edge && !freeze;

    always_ff @(posedge CLK or negedge ARESETn) begin
        if (!ARESETn) begin
            pic_cnt    <= '0;
            depth_snap <= '0;
            depth_max  <= '0;
            err_sticky <= '0;
            freeze     <= 1'b0;
        end else begin
            if (cnt_clr) begin
                pic_cnt <= '0;
            end else if (pic_take) begin
                pic_cnt <= pic_cnt + 32'd1;
            end
            if (pic_take) begin
                depth_snap <= fifo_depth;
                depth_max  <= fifo_depth;
            end else if (fifo_depth > depth_max) begin
                depth_max <= fifo_depth;
            end
            // New error pulses are OR'd after the clear so they win over W1C.
            err_sticky <= (err_sticky & ~err_w1c) | err_in;
            if (ctrl_we) begin
                freeze <= wdata_q[CTRL_FREEZE];
            end
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (accept) state_n = ST_DECODE;
            ST_DECODE: state_n = ST_RESP;
            ST_RESP:   if (bus.rsp_ready) state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    // req_ready is registered so it stays low while reset is asserted.
    always_ff @(posedge CLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state       <= ST_IDLE;
            req_ready_q <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state       <= state_n;
            req_ready_q <= (state_n == ST_IDLE);
            if (accept) begin
                wr_q    <= bus.req_write;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (state == ST_DECODE) begin
                rsp_data_q <= dec_err ? 32'd0 : dec_data;
                rsp_err_q  <= dec_err;
            end
        end
    end

endmodule

// File: doc/pic_status_reg_slave.md
Name: pic_status_reg_slave

Overview:
- Register-bus responder (slave) for the per-picture status registers read by the bus master at picture start.
- Captures a snapshot of FIFO depth status on each picture_start rising edge.
- Tracks peak depth within the picture, a picture counter and sticky error flags.
- Serves master read/write requests through a valid/ready request/response handshake.

Parameters:
- BASE_ADDR, 32'h0000_1100, register window base; offsets below are added to it.
- ADDR_W, 32, request address width.
- DEPTH_W, 8, width of fifo_depth.
- ERR_W, 8, width of err_in and the sticky error register.
- BLOCK_ID, 32'hC0DE_0001, value returned by the ID register.

Ports:
- CLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- picture_start  in  1  picture start level; rising edge = new picture
- fifo_depth  in  DEPTH_W  current FIFO occupancy
- err_in  in  ERR_W  error event pulses, one bit per source
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  master accepts response
- rsp_data  out  32  read data; 0 for writes and errors
- rsp_err  out  1  decode or access error

Behaviour:
- Reset: ARESETn is asynchronous, active-low; clock is CLK. On reset assertion:
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0.
  - All registers = 0 except ID.
  - FSM = IDLE.
  - Reset mid-transaction drops it; no response is issued.
- Register map (offset from BASE_ADDR, word aligned):
  - 0x00 ID: RO, BLOCK_ID.
  - 0x04 PIC_CNT: RO, 32-bit picture count; wraps 0xFFFF_FFFF->0.
  - 0x08 DEPTH_SNAP: RO, fifo_depth sampled at the picture_start edge, zero-extended.
  - 0x0C DEPTH_MAX: RO, maximum fifo_depth since the last picture_start edge.
  - 0x10 ERR_STICKY: W1C, bit set by err_in pulse.
  - 0x14 CTRL: RW bit0 FREEZE, bit1 CNT_CLR (self-clearing); other bits read 0.
- Picture edge: pic_edge = picture_start & ~picture_start_d (registered).
  - If FREEZE=0, on the edge cycle: PIC_CNT+=1; DEPTH_SNAP<=fifo_depth; DEPTH_MAX<=fifo_depth.
  - Otherwise DEPTH_MAX<=max(DEPTH_MAX, fifo_depth) every cycle.
  - FREEZE=1: the edge is ignored entirely; DEPTH_MAX keeps tracking.
- CNT_CLR write: PIC_CNT<=0 next cycle. If a picture edge occurs in the same cycle, clear wins and PIC_CNT=0.
- ERR_STICKY: next = (cur & ~w1c_mask) | err_in. A new set wins over a simultaneous W1C of the same bit.
- FSM IDLE / DECODE / RESP:
  - IDLE: req_ready=1. On handshake, latch write, addr and wdata, then go to DECODE.
  - DECODE: req_ready=0. Decode the address; perform the write or mux the read data; compute err; go to RESP.
  - RESP: rsp_valid=1 with rsp_data/rsp_err held stable until rsp_ready. On rsp_valid&&rsp_ready go to IDLE (req_ready=1 the next cycle).
  - Latency: rsp_valid rises 2 cycles after request acceptance. Max throughput is 1 transaction per 3 cycles.
- Errors:
  - Unmapped or unaligned (addr[1:0]!=0) address: rsp_err=1, rsp_data=0, no side effect.
  - Write to an RO register: rsp_err=1, no effect.
  - Write to W1C/RW register: rsp_err=0, rsp_data=0.
- Read coherency: read data is sampled in DECODE. A picture edge in the same cycle returns the pre-edge value.

Optional Feature:
- Macro PIC_SYNC_EN.
- Defined: picture_start passes through a 2-flop synchronizer before edge detection, so the snapshot occurs 3 cycles after the input rise. fifo_depth is sampled at that cycle.
- Undefined: picture_start is used directly, with 1-cycle edge detection.

Decomposition:
- Package pic_status_pkg:
  - Register offset localparams (OFS_ID, OFS_PIC_CNT, OFS_DEPTH_SNAP, OFS_DEPTH_MAX, OFS_ERR, OFS_CTRL).
  - FSM state enum typedef (ST_IDLE, ST_DECODE, ST_RESP).
  - CTRL bit-index constants.
- One sub-module: pic_edge_sync. It contains the optional synchronizer plus the rising-edge detector and outputs pic_edge.

Test Plan:
- Reset, then read BASE+0x00 -> rsp_valid 2 cycles after accept, rsp_data=BLOCK_ID, rsp_err=0. After reset, PIC_CNT/DEPTH_SNAP read 0.
- fifo_depth=5, picture_start rise, then fifo_depth=9, 3, then read DEPTH_SNAP/DEPTH_MAX/PIC_CNT -> 5 / 9 / 1.
- err_in bit2 pulse, write ERR 0x04 in the same cycle as a new bit2 pulse -> ERR reads 0x04. Write 0x04 again without a pulse -> reads 0x00.
- Read 0x18 (unmapped), then write 0x08 (RO) -> both rsp_err=1, rsp_data=0; DEPTH_SNAP unchanged.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0. Second req_valid is not accepted until 1 cycle after the response handshake.
- Write CTRL=1 (FREEZE), fire 3 picture edges -> PIC_CNT unchanged. Write CTRL=2 together with an edge -> PIC_CNT=0.
